// File: rtl/seq_detector_pkg.sv
// Shared constants and width helpers for the button-sequence detector.
package seq_detector_pkg;

    // Debounce counter width used on the Nexys-4 DDR board (100 MHz clock).
    localparam int BOARD_DB_BITS = 18;

    // Symbol width: enough bits to hold a button index, never less than one.
    function automatic int sym_width(input int num_btn);
        return (num_btn <= 2) ? 1 : $clog2(num_btn);
    endfunction

    // Fill counter width: must be able to hold the value PAT_LEN itself.
    function automatic int fill_width(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/seq_detector_debounce_pulse.sv
// Per-button conditioning: 2-flop synchroniser, press debounce counter,
// clean level (released immediately, no release debounce) and a one-cycle
// press pulse on the rising edge of the clean level.
module debounce_pulse
    import seq_detector_pkg::*;
#(
    parameter int DB_BITS = BOARD_DB_BITS
) (
    input  logic clock,
    input  logic reset_n,
    input  logic raw,
    output logic clean,
    output logic press
);

    logic               sync1_q;
    logic               sync2_q;
    logic [DB_BITS-1:0] cnt_q;
    logic [DB_BITS-1:0] cnt_d;
    logic               clean_q;
    logic               clean_d;
    logic               clean_prev_q;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Count stable-high cycles; the counter parks at all-ones so a long hold
    // cannot wrap around and re-arm the clean level.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (!sync2_q) begin
            cnt_d   = '0;
            clean_d = 1'b0;
        end else begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q == '1) begin
                clean_d = 1'b1;
            end
        end
    end

    // Debounce counter, clean flag and the delayed clean used for edge detect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            clean_q      <= 1'b0;
            clean_prev_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            clean_q      <= clean_d;
            clean_prev_q <= clean;
        end
    end

    // Clean drops in the same cycle the synchronised level drops.
    assign clean = clean_q & sync2_q;
    assign press = clean & ~clean_prev_q;

endmodule

// File: rtl/seq_detector.sv
// Button-sequence detector: debounces NUM_BTN buttons, turns each single
// clean press into a symbol, and flags when the last PAT_LEN symbols equal
// the runtime pattern (pattern slice 0 is the oldest press).
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int  NUM_BTN = 2,
    parameter int  PAT_LEN = 4,
    parameter int  DB_BITS = BOARD_DB_BITS,
    parameter int  CNT_W   = 8,
    localparam int SYM_W   = sym_width(NUM_BTN)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_BTN-1:0]       btn,
    input  logic [PAT_LEN*SYM_W-1:0] pattern,
    input  logic                     overlap_en,
    output logic                     match,
    output logic                     toggle_out,
    output logic [CNT_W-1:0]         match_count,
    output logic                     press_seen
);

    localparam int                HIST_W    = PAT_LEN * SYM_W;
    localparam int                FILL_W    = fill_width(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [NUM_BTN-1:0] clean_lvl;
    logic [NUM_BTN-1:0] press_vec;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        debounce_pulse #(
            .DB_BITS(DB_BITS)
        ) u_db (
            .clock  (clock),
            .reset_n(reset_n),
            .raw    (btn[g]),
            .clean  (clean_lvl[g]),
            .press  (press_vec[g])
        );
    end

    logic [HIST_W-1:0] hist_q;
    logic [HIST_W-1:0] hist_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    logic [FILL_W-1:0] fill_inc;
    logic              match_q;
    logic              match_d;
    logic              toggle_q;
    logic              toggle_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              press_seen_q;
    logic              press_seen_d;
    logic [3:0]        n_press;
    logic [SYM_W-1:0]  sym;
    logic              ev_valid;
    logic              ev_multi;
    logic              hit;

    // Classify this cycle's presses: none, exactly one (valid) or several.
    always_comb begin
        n_press = 4'd0;
        sym     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (press_vec[i]) begin
                n_press = n_press + 4'd1;
                sym     = SYM_W'(i);
            end
        end
        ev_valid = (n_press == 4'd1);
        ev_multi = (n_press > 4'd1);
    end

    // History/fill update and match decision, using the post-shift history.
    always_comb begin
        hist_d       = hist_q;
        fill_d       = fill_q;
        fill_inc     = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        hit          = 1'b0;
        match_d      = 1'b0;
        press_seen_d = 1'b0;
        toggle_d     = toggle_q;
        count_d      = count_q;
        if (ev_valid) begin
            hist_d       = {sym, hist_q[HIST_W-1:SYM_W]};
            hit          = (fill_inc == FILL_FULL) && (hist_d == pattern);
            fill_d       = (hit && !overlap_en) ? '0 : fill_inc;
            press_seen_d = 1'b1;
        end else if (ev_multi) begin
            // Ambiguous input aborts any partial sequence.
            fill_d = '0;
        end
        if (hit) begin
            match_d  = 1'b1;
            toggle_d = ~toggle_q;
            if (count_q != '1) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Sequence state and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hist_q       <= '0;
            fill_q       <= '0;
            match_q      <= 1'b0;
            toggle_q     <= 1'b0;
            count_q      <= '0;
            press_seen_q <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            fill_q       <= fill_d;
            match_q      <= match_d;
            toggle_q     <= toggle_d;
            count_q      <= count_d;
            press_seen_q <= press_seen_d;
        end
    end

    assign match       = match_q;
    assign toggle_out  = toggle_q;
    assign match_count = count_q;
    assign press_seen  = press_seen_q;

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: instance A (PAT_LEN=3) and instance B (PAT_LEN=4),
// both NUM_BTN=2, DB_BITS=2, checked against a press-level sequence model.
module tb_seq_detector;

    logic       clock;
    logic       reset_n;
    logic [1:0] btn_a;
    logic [1:0] btn_b;
    logic [2:0] pat_a;
    logic [3:0] pat_b;
    logic       ovl_a;
    logic       ovl_b;
    logic       match_a;
    logic       match_b;
    logic       tog_a;
    logic       tog_b;
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
    logic       ps_a;
    logic       ps_b;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no end of test, required end of test");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    seq_detector #(.NUM_BTN(2), .PAT_LEN(3), .DB_BITS(2), .CNT_W(8)) dut_a (
        .clock      (clock),
        .reset_n    (reset_n),
        .btn        (btn_a),
        .pattern    (pat_a),
        .overlap_en (ovl_a),
        .match      (match_a),
        .toggle_out (tog_a),
        .match_count(cnt_a),
        .press_seen (ps_a)
    );

    seq_detector #(.NUM_BTN(2), .PAT_LEN(4), .DB_BITS(2), .CNT_W(8)) dut_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .btn        (btn_b),
        .pattern    (pat_b),
        .overlap_en (ovl_b),
        .match      (match_b),
        .toggle_out (tog_b),
        .match_count(cnt_b),
        .press_seen (ps_b)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // ---------------- reference model (press level) ----------------
    int m_hist [2][16];   // [0] oldest
    int m_pat  [2][16];
    int m_plen [2];
    int m_fill [2];
    int m_cnt  [2];
    int m_tog  [2];
    int m_ovl  [2];
    int m_press[2];
    int m_match[2];
    int o_press[2];
    int o_match[2];
    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) m_hist[d][i] = 0;
            m_fill[d]  = 0;
            m_cnt[d]   = 0;
            m_tog[d]   = 0;
            m_press[d] = 0;
            m_match[d] = 0;
            o_press[d] = 0;
            o_match[d] = 0;
        end
        exp_q_a.delete();
        exp_q_b.delete();
    endtask

    // One debounced event: mask 1 -> symbol 0, 2 -> symbol 1, 3 -> both.
    task automatic model_event(input int d, input int mask);
        bit same;
        if (mask == 3) begin
            m_fill[d] = 0;
        end else if (mask != 0) begin
            for (int i = 0; i < m_plen[d] - 1; i++) m_hist[d][i] = m_hist[d][i+1];
            m_hist[d][m_plen[d]-1] = (mask == 2) ? 1 : 0;
            m_fill[d]  = (m_fill[d] + 1 > m_plen[d]) ? m_plen[d] : m_fill[d] + 1;
            m_press[d] = m_press[d] + 1;
            same = 1'b1;
            for (int i = 0; i < m_plen[d]; i++) if (m_hist[d][i] != m_pat[d][i]) same = 1'b0;
            if (m_fill[d] == m_plen[d] && same) begin
                if (m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
                m_tog[d]   = 1 - m_tog[d];
                m_match[d] = m_match[d] + 1;
                if (d == 0) exp_q_a.push_back(8'(m_cnt[d]));
                else        exp_q_b.push_back(8'(m_cnt[d]));
                if (m_ovl[d] == 0) m_fill[d] = 0;
            end
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (reset_n) begin
            if (ps_a) o_press[0] = o_press[0] + 1;
            if (ps_b) o_press[1] = o_press[1] + 1;
            if (match_a) begin
                o_match[0] = o_match[0] + 1;
                check_eq("match_a_expected", 32'(exp_q_a.size() != 0), 1);
                if (exp_q_a.size() != 0) check_eq("match_a_count", 32'(cnt_a), 32'(exp_q_a.pop_front()));
            end
            if (match_b) begin
                o_match[1] = o_match[1] + 1;
                check_eq("match_b_expected", 32'(exp_q_b.size() != 0), 1);
                if (exp_q_b.size() != 0) check_eq("match_b_count", 32'(cnt_b), 32'(exp_q_b.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_pat(input int d, input logic [15:0] v);
        for (int i = 0; i < 16; i++) m_pat[d][i] = int'(v[i]);
        if (d == 0) pat_a = v[2:0];
        else        pat_b = v[3:0];
    endtask

    task automatic set_ovl(input int d, input bit v);
        m_ovl[d] = int'(v);
        if (d == 0) ovl_a = v;
        else        ovl_b = v;
    endtask

    task automatic drive_press(input int d, input int mask, input int hold, input int gap);
        model_event(d, mask);
        @(negedge clock);
        if (d == 0) btn_a = 2'(mask);
        else        btn_b = 2'(mask);
        repeat (hold) @(negedge clock);
        if (d == 0) btn_a = 2'b00;
        else        btn_b = 2'b00;
        repeat (gap) @(negedge clock);
    endtask

    task automatic press_seq(input int d, input int sym0, input int sym1, input int sym2, input int sym3, input int n);
        int s[4];
        s = '{sym0, sym1, sym2, sym3};
        for (int i = 0; i < n; i++) drive_press(d, (s[i] == 1) ? 2 : 1, 6, 8);
    endtask

    task automatic check_all(input int d, input string tag);
        check_eq({tag, "_count"},   32'((d == 0) ? cnt_a : cnt_b), 32'(m_cnt[d]));
        check_eq({tag, "_toggle"},  32'((d == 0) ? tog_a : tog_b), 32'(m_tog[d]));
        check_eq({tag, "_presses"}, 32'(o_press[d]), 32'(m_press[d]));
        check_eq({tag, "_matches"}, 32'(o_match[d]), 32'(m_match[d]));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first_edge;
        int pulses;
        reset_n = 1'b0;
        btn_a   = 2'b00;
        btn_b   = 2'b00;
        m_plen[0] = 3;
        m_plen[1] = 4;
        model_reset();
        set_pat(0, 16'b100);      // presses 0,0,1
        set_pat(1, 16'b1010);     // presses 0,1,0,1
        set_ovl(0, 1'b0);
        set_ovl(1, 1'b1);
        repeat (3) @(negedge clock);
        check_eq("reset_match_a", 32'(match_a), 0);
        check_eq("reset_cnt_a",   32'(cnt_a), 0);
        check_eq("reset_tog_a",   32'(tog_a), 0);
        check_eq("reset_ps_a",    32'(ps_a), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Latency: raw high sampled at edge 1 -> press_seen after edge 7.
        model_event(0, 1);
        first_edge = 0;
        pulses     = 0;
        btn_a      = 2'b01;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clock);
            #1;
            if (ps_a) begin
                if (first_edge == 0) first_edge = e;
                pulses++;
            end
            if (e == 10) btn_a = 2'b00;
        end
        check_eq("latency_edge",   32'(first_edge), 7);
        check_eq("latency_pulses", 32'(pulses), 1);
        repeat (4) @(negedge clock);
        check_all(0, "latency");

        // 0,0,1 completes the pattern.
        press_seq(0, 0, 0, 1, 0, 3);
        check_all(0, "p001");

        // 0,0,0,1: repeated first symbol tolerated, one match.
        press_seq(0, 0, 0, 0, 1, 4);
        check_all(0, "p0001");

        // Bounce does not produce a press and leaves the history alone.
        press_seq(0, 0, 0, 0, 0, 2);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            btn_a = ~btn_a & 2'b01;
        end
        btn_a = 2'b00;
        repeat (8) @(negedge clock);
        check_all(0, "bounce");
        press_seq(0, 1, 0, 0, 0, 1);
        check_all(0, "bounce_then_1");

        // Simultaneous press aborts 0,0 so the following 1 cannot match.
        press_seq(0, 0, 0, 0, 0, 2);
        drive_press(0, 3, 6, 8);
        press_seq(0, 1, 0, 0, 0, 1);
        check_all(0, "multi_abort");
        press_seq(0, 0, 0, 1, 0, 3);
        check_all(0, "multi_restart");

        // Instance B, overlapping matches on 0,1,0,1,0,1.
        press_seq(1, 0, 1, 0, 1, 4);
        press_seq(1, 0, 1, 0, 0, 2);
        check_all(1, "ovl_on");

        // Reset mid-debounce: outputs clear at once, nothing is issued later.
        @(negedge clock);
        btn_b = 2'b01;
        repeat (3) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("midreset_cnt_a",   32'(cnt_a), 0);
        check_eq("midreset_cnt_b",   32'(cnt_b), 0);
        check_eq("midreset_tog_a",   32'(tog_a), 0);
        check_eq("midreset_tog_b",   32'(tog_b), 0);
        check_eq("midreset_match_b", 32'(match_b), 0);
        check_eq("midreset_ps_b",    32'(ps_b), 0);
        model_reset();
        @(negedge clock);
        btn_b = 2'b00;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        check_all(1, "after_reset");

        // Instance B without overlap: only one match.
        set_ovl(1, 1'b0);
        press_seq(1, 0, 1, 0, 1, 4);
        press_seq(1, 0, 1, 0, 0, 2);
        check_all(1, "ovl_off");

        // Randomised run on instance A with runtime pattern/overlap changes.
        for (int it = 0; it < 60; it++) begin
            int r;
            int mask;
            if ($urandom_range(0, 4) == 0) set_pat(0, 16'($urandom_range(0, 7)));
            if ($urandom_range(0, 4) == 0) set_ovl(0, 1'($urandom_range(0, 1)));
            r    = $urandom_range(0, 9);
            mask = (r == 0) ? 3 : ((r < 5) ? 1 : 2);
            drive_press(0, mask, $urandom_range(5, 9), $urandom_range(7, 10));
            if (it % 10 == 9) check_all(0, "random");
        end

        repeat (5) @(negedge clock);
        check_all(0, "final_a");
        check_all(1, "final_b");
        check_eq("exp_q_a_drained", 32'(exp_q_a.size()), 0);
        check_eq("exp_q_b_drained", 32'(exp_q_b.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
